// File: rtl/qpsk_rx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// qpsk_rx_frame_ctrl
//
// Receive-side frame sequencer that sits behind the QPSK hard-decision slicer.
// It takes one dibit per sym_valid and works through these steps:
//   1. Hunt for the sync word.
//   2. Read the length byte.
//   3. Pack the payload dibits MSB-first into bytes.
// The bytes go into a small FIFO. They leave over a valid/ready stream, and
// m_last marks the final payload byte of each frame.
//
// Optional feature: define QPSK_RX_CRC_EN to add a trailing CRC-8 byte
// (poly 0x07, init 0x00, no reflection). The CRC covers the length byte and
// the payload bytes. The CRC byte is checked and is never forwarded.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           receiver enable; low forces HUNT and clears frame state
//   sym_valid        slicer symbol strobe
//   sym_data[1:0]    slicer dibit
//   m_data[7:0]      payload byte        (stream out)
//   m_valid          byte available      (stream out)
//   m_ready          downstream accept   (stream in)
//   m_last           m_data is the final payload byte of a frame
//   frame_start      1-cycle pulse: sync word matched
//   frame_done       1-cycle pulse: frame completed
//   frame_err        1-cycle pulse: zero length, timeout, overflow or CRC fail
//   busy             state is not HUNT
//   ovf_sticky       sticky FIFO overflow flag
//   clr_ovf          clears ovf_sticky (a new overflow in the same cycle wins)
// ----------------------------------------------------------------------------
module qpsk_rx_frame_ctrl #(
  parameter int unsigned            SYNC_LEN   = 8,
  parameter logic [2*SYNC_LEN-1:0]  SYNC_WORD  = 16'h1ACF,
  parameter int unsigned            FIFO_DEPTH = 8,
  parameter int unsigned            TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy,
  output logic       ovf_sticky,
  input  logic       clr_ovf
);

  localparam int unsigned SW = 2 * SYNC_LEN;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CRC} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sync_q, sync_d;
  logic [7:0]     byte_q, byte_d;     // shared dibit packer for len/payload/crc
  logic [1:0]     dib_q, dib_d;       // dibit index within the current byte
  logic [7:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;       // payload bytes completed in this frame
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           drop_q, drop_d;     // a byte of this frame was dropped
  logic           start_q, start_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q;
  logic           ovf_q, ovf_d;
`ifdef QPSK_RX_CRC_EN
  logic [7:0]     crc_q, crc_d;
`endif

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [8:0]     fifo_mem_q [FIFO_DEPTH];

  logic [SW-1:0]  sync_shift;
  logic [7:0]     byte_shift;
  logic           in_frame, fifo_full, pop, push, push_last, wr_en, drop, to_hunt;

`ifdef QPSK_RX_CRC_EN
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign sync_shift = {sync_q[SW-3:0], sym_data};
  assign byte_shift = {byte_q[5:0], sym_data};
  assign in_frame   = (state_q != ST_HUNT);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = (count_q != '0) && m_ready;
  // A push into a full FIFO fits only if the head leaves in the same cycle.
  assign wr_en      = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // Frame sequencing
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    byte_d    = byte_q;
    dib_d     = dib_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    to_hunt   = 1'b0;
`ifdef QPSK_RX_CRC_EN
    crc_d     = crc_q;
`endif

    if (!enable) begin
      to_hunt = 1'b1;
    end else if (in_frame && !sym_valid && tmo_q == TW'(TIMEOUT - 1)) begin
      // The idle count reaches TIMEOUT on this edge. Abort and drop any partial byte.
      to_hunt = 1'b1;
      err_d   = 1'b1;
    end else begin
      if (in_frame) tmo_d = sym_valid ? '0 : tmo_q + TW'(1);
      if (sym_valid) begin
        case (state_q)
          ST_HUNT: begin
            sync_d = sync_shift;
            if (sync_shift == SYNC_WORD) begin
              state_d = ST_LEN;
              start_d = 1'b1;
            end
          end
          ST_LEN: begin
            byte_d = byte_shift;
            dib_d  = dib_q + 2'd1;
            if (dib_q == 2'd3) begin
              len_d = byte_shift;
              cnt_d = '0;
              if (byte_shift == 8'd0) begin
                to_hunt = 1'b1;
                err_d   = 1'b1;
              end else begin
                state_d = ST_PAYLOAD;
`ifdef QPSK_RX_CRC_EN
                crc_d   = crc8_upd(8'h00, byte_shift);
`endif
              end
            end
          end
          ST_PAYLOAD: begin
            byte_d = byte_shift;
            dib_d  = dib_q + 2'd1;
            if (dib_q == 2'd3) begin
              push      = 1'b1;
              push_last = (cnt_q + 8'd1 == len_q);
              cnt_d     = cnt_q + 8'd1;
`ifdef QPSK_RX_CRC_EN
              crc_d     = crc8_upd(crc_q, byte_shift);
              if (push_last) state_d = ST_CRC;
`else
              if (push_last) begin
                to_hunt = 1'b1;
                done_d  = 1'b1;
                // This byte is a push, so it is dropped exactly when full with no pop.
                err_d   = drop_q | (fifo_full && !pop);
              end
`endif
            end
          end
`ifdef QPSK_RX_CRC_EN
          ST_CRC: begin
            byte_d = byte_shift;
            dib_d  = dib_q + 2'd1;
            if (dib_q == 2'd3) begin
              to_hunt = 1'b1;
              done_d  = 1'b1;
              err_d   = drop_q | (byte_shift != crc_q);
            end
          end
`endif
          default: to_hunt = 1'b1;
        endcase
      end
    end

    drop_d = drop_q | drop;

    // Every return to HUNT starts the next hunt from a clean slate.
    if (to_hunt) begin
      state_d = ST_HUNT;
      sync_d  = '0;
      byte_d  = '0;
      dib_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      drop_d  = 1'b0;
    end

    // A new overflow beats a simultaneous clear.
    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= {push_last, byte_shift};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      sync_q   <= '0;
      byte_q   <= '0;
      dib_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      drop_q   <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef QPSK_RX_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      byte_q   <= byte_d;
      dib_q    <= dib_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      drop_q   <= drop_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != ST_HUNT);
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef QPSK_RX_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  // The head entry is masked while the FIFO is empty. This keeps the stream outputs at 0 after reset.
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? fifo_mem_q[rd_ptr_q][7:0] : 8'h00;
  assign m_last      = m_valid ? fifo_mem_q[rd_ptr_q][8]   : 1'b0;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_qpsk_rx_frame_ctrl.sv
// Directed testbench for qpsk_rx_frame_ctrl. It is self-checking through immediate assertions.
module tb_qpsk_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enable, sym_valid, m_ready, clr_ovf;
  logic [1:0] sym_data;
  logic [7:0] m_data;
  logic       m_valid, m_last, frame_start, frame_done, frame_err, busy, ovf_sticky;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] rx_q [$];
  logic       err_seen;
`ifdef QPSK_RX_CRC_EN
  logic [7:0] crc_acc;
  logic [7:0] crc_tx;
`endif

  always #5 clk = ~clk;

  qpsk_rx_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy),
    .ovf_sticky  (ovf_sticky),
    .clr_ovf     (clr_ovf)
  );

  // Record every byte the DUT hands off. The handshake is sampled mid-cycle, ahead of the edge that pops the byte.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) rx_q.push_back({m_last, m_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_sym(input logic [1:0] d);
    sym_valid = 1'b1;
    sym_data  = d;
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

`ifdef QPSK_RX_CRC_EN
  function automatic logic [7:0] crc8_bits(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_sym(b[2*i +: 2]);
`ifdef QPSK_RX_CRC_EN
    crc_acc = crc8_bits(crc_acc, b);
`endif
  endtask

  // Symbols 0,1,2,2,3,0,3,3
  task automatic send_sync();
    logic [15:0] w;
    w = 16'h1ACF;
    for (int i = 7; i >= 0; i--) send_sym(w[2*i +: 2]);
`ifdef QPSK_RX_CRC_EN
    crc_acc = 8'h00;
`endif
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sym_valid = 1'b0; sym_data = 2'd0;
    m_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {m_valid, m_last, m_data, frame_start, frame_done, frame_err, busy, ovf_sticky}, 0);
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // ---- sync + 2-byte frame, m_ready=1 ----
    send_sync();
    chk("f1_start", frame_start, 1);
    chk("f1_busy", busy, 1);
    send_byte(8'h02);
    chk("f1_start_pulse_end", frame_start, 0);
    chk("f1_len_err", frame_err, 0);
    send_byte(8'hA5);
    chk("f1_b0_head", {m_valid, m_last, m_data}, 10'h2A5);
    send_byte(8'h3C);
    chk("f1_b1_head", {m_valid, m_last, m_data}, 10'h33C);
`ifdef QPSK_RX_CRC_EN
    chk("f1_done_before_crc", frame_done, 0);
    crc_tx = crc_acc;
    send_byte(crc_tx);
`endif
    chk("f1_done", frame_done, 1);
    chk("f1_err", frame_err, 0);
    tick();
    chk("f1_after", {frame_done, busy, m_valid}, 0);
    chk("f1_nbytes", rx_q.size(), 2);
    chk("f1_rx0", rx_q[0], 9'h0A5);
    chk("f1_rx1", rx_q[1], 9'h13C);
    rx_q.delete();

    // ---- zero length ----
    send_sync();
    send_byte(8'h00);
    chk("zl_err", frame_err, 1);
    chk("zl_done", frame_done, 0);
    chk("zl_busy", busy, 0);
    tick();
    chk("zl_err_pulse", frame_err, 0);
    chk("zl_nopush", {m_valid, 32'(rx_q.size())}, 0);

    // ---- overflow: m_ready=0, len=10 ----
    m_ready = 1'b0;
    send_sync();
    send_byte(8'd10);
    for (int i = 1; i <= 10; i++) begin
      send_byte(8'(8'h10 + i));
      if (i == 8) chk("ovf_full_noflag", {m_valid, ovf_sticky}, 2'b10);
      if (i == 9) begin
        chk("ovf_flag", ovf_sticky, 1);
        chk("ovf_no_early_err", frame_err, 0);
        chk("ovf_head_hold", {m_last, m_data}, 9'h011);
      end
    end
`ifdef QPSK_RX_CRC_EN
    crc_tx = crc_acc;
    send_byte(crc_tx);
`endif
    chk("ovf_done_err", {frame_done, frame_err}, 2'b11);
    tick();
    chk("ovf_sticky_hold", ovf_sticky, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", ovf_sticky, 0);
    m_ready = 1'b1;
    repeat (10) tick();
    chk("ovf_nbytes", rx_q.size(), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("ovf_rx%0d", k), rx_q[k], {1'b0, 8'(8'h11 + k)});
    rx_q.delete();

    // ---- timeout after 2 payload dibits ----
    send_sync();
    send_byte(8'h01);
    send_sym(2'd2);
    send_sym(2'd1);
    err_seen = 1'b0;
    repeat (1023) begin
      tick();
      if (frame_err) err_seen = 1'b1;
    end
    chk("tmo_not_early", err_seen, 0);
    chk("tmo_busy_before", busy, 1);
    tick();
    chk("tmo_err", frame_err, 1);
    chk("tmo_hunt", busy, 0);
    tick();
    chk("tmo_no_byte", {m_valid, 32'(rx_q.size())}, 0);

    // ---- enable low mid-frame ----
    send_sync();
    send_byte(8'h03);
    send_sym(2'd1);
    enable = 1'b0;
    tick();
    chk("en_low_hunt", {busy, frame_start, frame_done, frame_err}, 0);
    send_sync();
    chk("en_low_ignore", {busy, frame_start}, 0);
    enable = 1'b1;

    // ---- reset mid-frame ----
    m_ready = 1'b0;
    send_sync();
    send_byte(8'h02);
    send_byte(8'h77);
    send_sym(2'd1);
    chk("rst_pre_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {m_valid, m_last, m_data, frame_start, frame_done, frame_err, busy, ovf_sticky}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    send_sync();
    chk("rst_resync", frame_start, 1);
    send_byte(8'h01);
    send_byte(8'h5A);
    chk("rst_f_head", {m_valid, m_last, m_data}, 10'h35A);
`ifdef QPSK_RX_CRC_EN
    crc_tx = crc_acc;
    send_byte(crc_tx);
`endif
    chk("rst_f_done", {frame_done, frame_err}, 2'b10);
    tick();
    chk("rst_nbytes", rx_q.size(), 1);
    chk("rst_rx0", rx_q[0], 9'h15A);
    rx_q.delete();

`ifdef QPSK_RX_CRC_EN
    // ---- CRC good / bad ----
    send_sync();
    send_byte(8'h01);
    send_byte(8'h01);
    crc_tx = crc_acc;
    send_byte(crc_tx);
    chk("crc_good", {frame_done, frame_err}, 2'b10);
    send_sync();
    send_byte(8'h01);
    send_byte(8'h01);
    chk("crc_bad_head", {m_valid, m_last, m_data}, 10'h301);
    crc_tx = crc_acc ^ 8'hFF;
    send_byte(crc_tx);
    chk("crc_bad", {frame_done, frame_err}, 2'b11);
    tick();
    chk("crc_nbytes", rx_q.size(), 2);
    chk("crc_rx1", rx_q[1], 9'h101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
